// File: rtl/fpga_io_cond.sv
// Purpose : per-channel pad conditioner: synchroniser, glitch filter, edge pulses, activity LED stretch.
// Latency : a held pin change reaches o_level/o_rise/o_fall SYNC_STAGES+FILT_LEN sysclk cycles after the first sampling edge.
// Backpr. : none; free-running, every channel is processed every cycle.
//
// Ports:
//   sysclk     - system clock, all state on rising edge
//   spi_rst_ni - asynchronous active-low reset; sync stages and o_level go to IDLE_VAL
//   i_pin      - raw asynchronous pad inputs, one per channel
//   o_level    - synchronised, glitch-filtered level
//   o_rise     - one-cycle registered pulse on filtered 0->1
//   o_fall     - one-cycle registered pulse on filtered 1->0
//   o_led      - activity LED drive
//   o_act_any  - OR of o_led
//
// Build option: define FPGA_IO_COND_STRETCH_EN to build per-channel LED stretch counters
// (LED held for 2^STRETCH_W-1 cycles after each edge, retriggerable). Without it the LED
// simply shows o_level XOR IDLE_VAL, i.e. "channel is away from its idle level".
module fpga_io_cond #(
    parameter int             NCH         = 4,
    parameter int             SYNC_STAGES = 2,
    parameter int             FILT_LEN    = 3,
    parameter int             STRETCH_W   = 20,
    parameter logic [NCH-1:0] IDLE_VAL    = '0
) (
    input  logic           sysclk,
    input  logic           spi_rst_ni,
    input  logic [NCH-1:0] i_pin,
    output logic [NCH-1:0] o_level,
    output logic [NCH-1:0] o_rise,
    output logic [NCH-1:0] o_fall,
    output logic [NCH-1:0] o_led,
    output logic           o_act_any
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

    // Synchroniser chain; every stage resets to the idle level so that a
    // reset release with the pins idle cannot look like an edge.
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync_s;

    always_ff @(posedge sysclk or negedge spi_rst_ni) begin
        if (!spi_rst_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= IDLE_VAL;
            end
        end else begin
            sync_q[0] <= i_pin;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Glitch filter: the counter tracks how long s has disagreed with the
    // filtered level. It flips the level on the FILT_LEN-th consecutive
    // disagreeing cycle; any agreement in between restarts the count.
    logic [FW-1:0]  filt_cnt [NCH];
    logic [NCH-1:0] level_q;
    logic [NCH-1:0] rise_q;
    logic [NCH-1:0] fall_q;

    always_ff @(posedge sysclk or negedge spi_rst_ni) begin
        if (!spi_rst_ni) begin
            level_q <= IDLE_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                filt_cnt[ch] <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (sync_s[ch] == level_q[ch]) begin
                    filt_cnt[ch] <= '0;
                end else if (filt_cnt[ch] == FILT_LAST) begin
                    // Pulse registers update on the same edge as the level,
                    // so the pulse coincides with the first cycle of the new level.
                    level_q[ch]  <= sync_s[ch];
                    rise_q[ch]   <= sync_s[ch];
                    fall_q[ch]   <= ~sync_s[ch];
                    filt_cnt[ch] <= '0;
                end else begin
                    filt_cnt[ch] <= filt_cnt[ch] + FW'(1);
                end
            end
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

`ifdef FPGA_IO_COND_STRETCH_EN
    // Retriggerable stretch: any edge pulse reloads to full, so a burst of
    // edges keeps the LED lit until 2^STRETCH_W-1 cycles after the last one.
    logic [STRETCH_W-1:0] str_cnt [NCH];
    logic [NCH-1:0]       led_c;

    always_ff @(posedge sysclk or negedge spi_rst_ni) begin
        if (!spi_rst_ni) begin
            for (int ch = 0; ch < NCH; ch++) begin
                str_cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (rise_q[ch] || fall_q[ch]) begin
                    str_cnt[ch] <= '1;
                end else if (str_cnt[ch] != '0) begin
                    str_cnt[ch] <= str_cnt[ch] - STRETCH_W'(1);
                end
            end
        end
    end

    always_comb begin
        led_c = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            led_c[ch] = (str_cnt[ch] != '0);
        end
    end

    assign o_led = led_c;
`else
    // level_q resets to IDLE_VAL, so this is 0 throughout reset.
    assign o_led = level_q ^ IDLE_VAL;
`endif

    assign o_act_any = |o_led;

endmodule

// File: tb/tb_fpga_io_cond.sv
// Purpose : self-checking bench for fpga_io_cond (NCH=4, SYNC=2, FILT=3, STRETCH_W=4, IDLE=0010).
// Latency : expected edge events are queued with their cycle number and checked by a monitor.
// Backpr. : n/a.
module tb_fpga_io_cond;

    logic       sysclk;
    logic       spi_rst_ni;
    logic [3:0] i_pin;
    logic [3:0] o_level;
    logic [3:0] o_rise;
    logic [3:0] o_fall;
    logic [3:0] o_led;
    logic       o_act_any;

    fpga_io_cond #(
        .NCH        (4),
        .SYNC_STAGES(2),
        .FILT_LEN   (3),
        .STRETCH_W  (4),
        .IDLE_VAL   (4'b0010)
    ) dut (
        .sysclk    (sysclk),
        .spi_rst_ni(spi_rst_ni),
        .i_pin     (i_pin),
        .o_level   (o_level),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .o_led     (o_led),
        .o_act_any (o_act_any)
    );

`ifdef FPGA_IO_COND_STRETCH_EN
    localparam bit STR = 1'b1;
`else
    localparam bit STR = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] level;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.level = l;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge; every edge pulse must match the
    // head of the expectation queue, and no expectation may be overtaken.
    always @(negedge sysclk) begin
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missed_pulse_cycle", cyc, e.cyc);
        end
        if ((o_rise | o_fall) != 4'b0000) begin
            chk("rise_and_fall_same_ch", o_rise & o_fall, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {o_rise, o_fall}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_rise", o_rise, e.rise);
                chk("pulse_fall", o_fall, e.fall);
                chk("pulse_level", o_level, e.level);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hi;
        spi_rst_ni = 1'b0;
        i_pin      = 4'b0010;
        tick(3);
        chk("rst_level", o_level, 4'b0010);
        chk("rst_rise", o_rise, 0);
        chk("rst_fall", o_fall, 0);
        chk("rst_led", o_led, 0);
        chk("rst_act_any", o_act_any, 0);

        // Release with pins idle: 100 quiet cycles.
        spi_rst_ni = 1'b1;
        tick(100);
        chk("idle_level", o_level, 4'b0010);
        chk("idle_led", o_led, 0);

        // ch0 rise, latency 5, LED stretch length.
        i_pin[0] = 1'b1;
        c = cyc;
        push(c + 5, 4'b0001, 4'b0000, 4'b0011);
        tick(4);
        chk("lat_level_edge4", o_level, 4'b0010);
        tick(1);
        chk("lat_level_edge5", o_level, 4'b0011);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (o_led[0]) hi++;
        end
        chk("led0_high_cycles", hi, STR ? 15 : 30);

        // ch2 two-cycle glitch is rejected.
        i_pin[2] = 1'b1;
        tick(2);
        i_pin[2] = 1'b0;
        tick(20);
        chk("glitch_level", o_level, 4'b0011);
        chk("glitch_led2", o_led[2], 0);

        // ch1 fall then rise 10 cycles later: stretch retrigger.
        i_pin[1] = 1'b0;
        c = cyc;
        push(c + 5, 4'b0000, 4'b0010, 4'b0001);
        tick(10);
        i_pin[1] = 1'b1;
        push(c + 15, 4'b0010, 4'b0000, 4'b0011);
        tick(4);
        chk("led1_c14", o_led[1], 1);
        tick(1);
        chk("led1_c15", o_led[1], STR ? 1 : 0);
        tick(15);
        chk("led1_c30", o_led[1], STR ? 1 : 0);
        tick(1);
        chk("led1_c31", o_led[1], 0);

        // ch0 fall, then reset while its stretch counter is at 8.
        i_pin[0] = 1'b0;
        c = cyc;
        push(c + 5, 4'b0000, 4'b0001, 4'b0010);
        tick(13);
        chk("led0_before_rst", o_led, STR ? 4'b0001 : 4'b0000);
        spi_rst_ni = 1'b0;
        #1;
        chk("midstr_rst_level", o_level, 4'b0010);
        chk("midstr_rst_led", o_led, 0);
        chk("midstr_rst_act_any", o_act_any, 0);
        chk("midstr_rst_pulses", {o_rise, o_fall}, 0);
        tick(1);
        spi_rst_ni = 1'b1;
        tick(30);
        chk("post_rst_level", o_level, 4'b0010);
        chk("post_rst_led", o_led, 0);

        // Reset mid-filter on ch3 with the pin still high: normal edge after release.
        i_pin = 4'b1010;
        tick(3);
        spi_rst_ni = 1'b0;
        #1;
        chk("midfilt_rst_level", o_level, 4'b0010);
        tick(1);
        spi_rst_ni = 1'b1;
        c = cyc;
        push(c + 5, 4'b1000, 4'b0000, 4'b1010);
        tick(10);
        i_pin = 4'b0010;
        c = cyc;
        push(c + 5, 4'b0000, 4'b1000, 4'b0010);
        tick(25);

        // All channels leave idle at once straight out of reset.
        spi_rst_ni = 1'b0;
        i_pin      = 4'b1101;
        tick(1);
        spi_rst_ni = 1'b1;
        c = cyc;
        push(c + 5, 4'b1101, 4'b0010, 4'b1101);
        tick(6);
        chk("all_led", o_led, 4'b1111);
        chk("all_act_any", o_act_any, 1);
        tick(5);
        i_pin = 4'b0010;
        c = cyc;
        push(c + 5, 4'b0010, 4'b1101, 4'b0010);
        tick(40);
        chk("all_back_level", o_level, 4'b0010);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
